// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall calls, scans them round-robin and sends each
// to the nearest eligible of two cars, with a per-car arrival watchdog.
module hall_call_dispatcher #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] call_btn,
    input  logic [3:0] elev1_floor,
    input  logic [3:0] elev2_floor,
    input  logic       elev1_ready,
    input  logic       elev2_ready,
    input  logic       elev1_arrived,
    input  logic       elev2_arrived,
    output logic [3:0] elev1_target,
    output logic [3:0] elev2_target,
    output logic       elev1_go,
    output logic       elev2_go,
    output logic       elev1_fault,
    output logic       elev2_fault,
    output logic [3:0] pending
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GO, WAIT} state_t;
    state_t        st [2];
    logic [3:0]    tgt [2];
    logic [3:0]    flr [2];
    logic [CW-1:0] cnt [2];
    logic [1:0]    e [2];
    logic [1:0]    d [2];
    logic [1:0]    rdy, arr, go, fault, elig, pick;
    logic [3:0]    assigned, cand, clr_arr, clr_flt;
    logic [1:0]    ptr, sel;
    logic          found;
    assign flr[0] = elev1_floor;
    assign flr[1] = elev2_floor;
    assign rdy = {elev2_ready, elev1_ready};
    assign arr = {elev2_arrived, elev1_arrived};
    assign elev1_target = tgt[0];
    assign elev2_target = tgt[1];
    assign {elev2_go, elev1_go} = go;
    assign {elev2_fault, elev1_fault} = fault;
    always_comb begin
        cand = pending & ~assigned;
        sel = ptr;
        found = 1'b0;
        // descending scan so the candidate closest after ptr is the one kept
        for (int i = 3; i >= 0; i--)
            if (cand[2'(ptr + 2'(i))]) begin
                sel = 2'(ptr + 2'(i));
                found = 1'b1;
            end
        clr_arr = '0;
        clr_flt = '0;
        for (int c = 0; c < 2; c++) begin
            e[c] = {flr[c][3] | flr[c][2], flr[c][3] | flr[c][1]};
            d[c] = e[c] > sel ? e[c] - sel : sel - e[c];
            elig[c] = st[c] == IDLE && rdy[c] && $onehot(flr[c]) && !fault[c];
            if (st[c] == WAIT && arr[c])
                clr_arr = clr_arr | tgt[c];
            if (st[c] == WAIT && !arr[c] && cnt[c] == CW'(TIMEOUT - 1))
                clr_flt = clr_flt | tgt[c];
        end
        pick[0] = found && elig[0] && (!elig[1] || d[0] <= d[1]);
        pick[1] = found && elig[1] && (!elig[0] || d[1] < d[0]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            assigned <= '0;
            ptr <= '0;
            go <= '0;
            fault <= '0;
            for (int c = 0; c < 2; c++) begin
                st[c] <= IDLE;
                tgt[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            // a button in the same cycle as an arrival re-raises the floor
            pending <= (pending & ~clr_arr) | call_btn;
            assigned <= (assigned & ~clr_arr & ~clr_flt) | (|pick ? 4'b0001 << sel : 4'b0000);
            if (|pick)
                ptr <= sel + 2'd1;
            go <= pick;
            for (int c = 0; c < 2; c++)
                case (st[c])
                    IDLE: if (pick[c]) begin
                        st[c] <= GO;
                        tgt[c] <= 4'b0001 << sel;
                    end
                    GO: begin
                        st[c] <= WAIT;
                        cnt[c] <= '0;
                    end
                    WAIT: if (arr[c])
                        st[c] <= IDLE;
                    else if (cnt[c] == CW'(TIMEOUT - 1)) begin
                        st[c] <= IDLE;
                        fault[c] <= 1'b1;
                    end else
                        cnt[c] <= cnt[c] + 1'b1;
                    default: st[c] <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// tb_hall_call_dispatcher: table vectors, directed corner sequences and random
// stimulus, all checked against a floor/age based reference model.
module tb_hall_call_dispatcher;
    localparam int TO = 8;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] call_btn, f1, f2;
    logic       r1, r2, a1, a2;
    logic [3:0] t1, t2, pending;
    logic       go1, go2, flt1, flt2;
    int checks = 0;
    int errors = 0;
    hall_call_dispatcher #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .call_btn(call_btn),
        .elev1_floor(f1), .elev2_floor(f2),
        .elev1_ready(r1), .elev2_ready(r2),
        .elev1_arrived(a1), .elev2_arrived(a2),
        .elev1_target(t1), .elev2_target(t2),
        .elev1_go(go1), .elev2_go(go2),
        .elev1_fault(flt1), .elev2_fault(flt2),
        .pending(pending)
    );
    always #5 clk = ~clk;
    // reference model: calls as a bitmap, cars as busy flag plus cycles since go
    logic [3:0] m_pend, m_asg;
    int         m_ptr;
    logic       m_busy [2];
    logic       m_fault [2];
    logic       m_go [2];
    int         m_age [2];
    int         m_tgt [2];
    logic [3:0] m_tout [2];
    function automatic int enc(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return 0;
    endfunction
    task automatic model_step();
        logic [3:0] fl [2];
        logic       rd [2];
        logic       ar [2];
        logic       el [2];
        int         dd [2];
        int         sel, w, f;
        fl[0] = f1; fl[1] = f2;
        rd[0] = r1; rd[1] = r2;
        ar[0] = a1; ar[1] = a2;
        if (reset) begin
            m_pend = '0; m_asg = '0; m_ptr = 0;
            for (int c = 0; c < 2; c++) begin
                m_busy[c] = 0; m_fault[c] = 0; m_go[c] = 0;
                m_age[c] = 0; m_tgt[c] = 0; m_tout[c] = '0;
            end
            return;
        end
        sel = -1;
        for (int k = 0; k < 4; k++) begin
            f = (m_ptr + k) % 4;
            if (sel < 0 && m_pend[f] && !m_asg[f]) sel = f;
        end
        for (int c = 0; c < 2; c++) begin
            el[c] = !m_busy[c] && !m_fault[c] && rd[c] && $onehot(fl[c]);
            dd[c] = enc(fl[c]) - sel;
            if (dd[c] < 0) dd[c] = -dd[c];
        end
        w = -1;
        if (sel >= 0) begin
            if (el[0] && (!el[1] || dd[0] <= dd[1])) w = 0;
            else if (el[1]) w = 1;
        end
        for (int c = 0; c < 2; c++) begin
            m_go[c] = 0;
            if (m_busy[c]) begin
                if (m_age[c] >= 1 && ar[c]) begin
                    m_pend[m_tgt[c]] = 0;
                    m_asg[m_tgt[c]] = 0;
                    m_busy[c] = 0;
                end else if (m_age[c] == TO) begin
                    m_asg[m_tgt[c]] = 0;
                    m_fault[c] = 1;
                    m_busy[c] = 0;
                end else
                    m_age[c]++;
            end
        end
        m_pend = m_pend | call_btn;
        if (w >= 0) begin
            m_busy[w] = 1; m_age[w] = 0; m_tgt[w] = sel;
            m_tout[w] = 4'b0001 << sel;
            m_asg[sel] = 1; m_ptr = (sel + 1) % 4; m_go[w] = 1;
        end
    endtask
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle", 32'({pending, t1, t2, go1, go2, flt1, flt2}),
            32'({m_pend, m_tout[0], m_tout[1], m_go[0], m_go[1], m_fault[0], m_fault[1]}));
    endtask
    task automatic do_reset();
        reset = 1'b1; call_btn = '0; a1 = 0; a2 = 0;
        tick();
        reset = 1'b0;
    endtask
    typedef struct {
        logic [3:0] btn, fa, fb;
        logic       ra, rb, aa, ab;
        logic [3:0] pend;
        logic       ga, gb;
        logic [3:0] ta, tb;
    } vec_t;
    vec_t tbl [13];
    initial begin
        tbl[0]  = '{4'b0100, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000};
        tbl[2]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000};
        tbl[3]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000};
        tbl[4]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000};
        tbl[5]  = '{4'b0010, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0100, 4'b0000};
        tbl[6]  = '{4'b0000, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b0100, 4'b0010};
        tbl[7]  = '{4'b0000, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0100, 4'b0010};
        tbl[8]  = '{4'b0000, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0010};
        tbl[9]  = '{4'b0100, 4'b0100, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0010};
        tbl[10] = '{4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0010};
        tbl[11] = '{4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0010};
        tbl[12] = '{4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0010};
        f1 = 4'b0001; f2 = 4'b0001; r1 = 1; r2 = 1;
        do_reset();
        chk("reset_state", 32'({pending, t1, t2, go1, go2, flt1, flt2}), 32'd0);
        for (int i = 0; i < 13; i++) begin
            call_btn = tbl[i].btn; f1 = tbl[i].fa; f2 = tbl[i].fb;
            r1 = tbl[i].ra; r2 = tbl[i].rb; a1 = tbl[i].aa; a2 = tbl[i].ab;
            tick();
            chk($sformatf("vec%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("vec%0d_go", i), 32'({go1, go2}), 32'({tbl[i].ga, tbl[i].gb}));
            chk($sformatf("vec%0d_tgt", i), 32'({t1, t2}), 32'({tbl[i].ta, tbl[i].tb}));
        end
        a1 = 0;
        // fairness and wrap: floor 2 first leaves the pointer at 3
        f1 = 4'b0001; r1 = 1; r2 = 0;
        do_reset();
        call_btn = 4'b0100; tick();
        call_btn = 4'b0000; tick();
        tick();
        a1 = 1; tick(); a1 = 0;
        call_btn = 4'b1001; tick();
        call_btn = 4'b0000; tick();
        chk("wrap_first", 32'({go1, t1}), 32'({1'b1, 4'b1000}));
        tick();
        a1 = 1; tick(); a1 = 0;
        chk("wrap_pend", 32'(pending), 32'(4'b0001));
        tick();
        chk("wrap_second", 32'({go1, t1}), 32'({1'b1, 4'b0001}));
        tick();
        a1 = 1; tick(); a1 = 0;
        call_btn = 4'b0011; tick();
        call_btn = 4'b0000; tick();
        chk("ptr_at_1", 32'({go1, t1}), 32'({1'b1, 4'b0010}));
        tick();
        a1 = 1; tick(); a1 = 0;
        tick();
        chk("ptr_then_0", 32'({go1, t1}), 32'({1'b1, 4'b0001}));
        tick();
        a1 = 1; tick(); a1 = 0;
        // arrival and button on the same floor in the same cycle
        f1 = 4'b0100;
        do_reset();
        call_btn = 4'b0100; tick();
        call_btn = 4'b0000; tick();
        tick();
        a1 = 1; call_btn = 4'b0100; tick();
        a1 = 0; call_btn = 4'b0000;
        chk("simul_pend", 32'(pending), 32'(4'b0100));
        tick();
        chk("simul_redispatch", 32'({go1, t1}), 32'({1'b1, 4'b0100}));
        // watchdog on elev2
        r1 = 0; f1 = 4'b0001; r2 = 1; f2 = 4'b0100;
        do_reset();
        call_btn = 4'b1000; tick();
        call_btn = 4'b0000; tick();
        chk("wd_go2", 32'({go2, t2}), 32'({1'b1, 4'b1000}));
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk($sformatf("wd_nofault%0d", k), 32'(flt2), 32'd0);
        end
        r1 = 1;
        tick();
        chk("wd_fault", 32'({flt2, pending}), 32'({1'b1, 4'b1000}));
        tick();
        chk("wd_redispatch", 32'({go1, t1, go2}), 32'({1'b1, 4'b1000, 1'b0}));
        tick();
        a1 = 1; tick(); a1 = 0;
        chk("wd_served", 32'(pending), 32'd0);
        call_btn = 4'b0100; tick();
        call_btn = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("wd_no_go2", 32'({go2, flt2}), 32'({1'b0, 1'b1}));
        end
        // reset while elev1 waits with three calls pending
        call_btn = 4'b1010; tick();
        call_btn = 4'b0000; tick();
        chk("rst_pre", 32'(pending), 32'(4'b1110));
        do_reset();
        chk("rst_mid", 32'({pending, t1, t2, go1, go2, flt1, flt2}), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_quiet", 32'({go1, go2, pending}), 32'd0);
        end
        // randomized traffic with periodic resets to revive faulted cars
        for (int i = 0; i < 1500; i++) begin
            reset = (i % 80 == 0);
            call_btn = ($urandom_range(4) == 0) ? 4'($urandom) : 4'b0000;
            f1 = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0001 << $urandom_range(3);
            f2 = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0001 << $urandom_range(3);
            r1 = ($urandom_range(3) != 0);
            r2 = ($urandom_range(3) != 0);
            a1 = ($urandom_range(3) == 0);
            a2 = ($urandom_range(3) == 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
